// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master transmitter and the slave-side receive blocks.
// Mode 0 only: clock idles low, data is sampled on the rising edge.
package spi_pkg;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Defaults chosen so a 2-flop synchroniser plus 2-cycle debouncer on the slave tracks every edge.
    localparam int SPI_DEFAULT_DATA_WIDTH = 8;
    localparam int SPI_DEFAULT_CLK_DIV    = 4;
    localparam int SPI_DEFAULT_CS_SETUP   = 2;
    localparam int SPI_DEFAULT_CS_HOLD    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: spi_clk toggles every CLK_DIV cycles while enabled, and
// rise_stb/fall_stb flag the cycle whose closing edge makes spi_clk rise or fall.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic spi_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase;
    logic          phase_end;

    assign phase_end = en && (phase == PHASE_LAST);
    assign rise_stb  = phase_end && (spi_clk == SPI_CPOL);
    assign fall_stb  = phase_end && (spi_clk != SPI_CPOL);

    // Dropping en parks the divider at phase 0 with the clock idle, so no count survives a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            spi_clk <= SPI_CPOL;
        end else if (!en) begin
            phase   <= '0;
            spi_clk <= SPI_CPOL;
        end else if (phase_end) begin
            phase   <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one accepted word per chip-select frame, MSB first, with the
// MISO word returned on o_rx_data alongside a one-cycle o_done pulse.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = SPI_DEFAULT_CLK_DIV,
    parameter int CS_SETUP   = SPI_DEFAULT_CS_SETUP,
    parameter int CS_HOLD    = SPI_DEFAULT_CS_HOLD
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    input  logic                  spi_miso,
    output spi_state_e            o_state
);

    // Handshake: a word transfers on the i_clk edge where i_valid && o_ready; o_ready is
    // high only in IDLE, i_valid seen while o_ready is low is dropped, nothing is queued.

    localparam int              BW         = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [7:0]      SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0]      HOLD_LAST  = 8'(CS_HOLD - 1);

    spi_state_e            state;
    spi_state_e            next_state;
    logic [7:0]            cs_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  accept;
    logic                  last_bit;
    logic                  frame_end;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (i_clk),
        .rst      (i_rst),
        .en       (state == SHIFT),
        .spi_clk  (spi_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign accept    = i_valid && o_ready;
    assign last_bit  = fall_stb && (bit_cnt == BIT_LAST);
    assign frame_end = (state == HOLD) && (cs_cnt == HOLD_LAST);
    assign spi_mosi  = tx_shift[DATA_WIDTH-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)                 next_state = SETUP;
            SETUP:   if (cs_cnt == SETUP_LAST)   next_state = SHIFT;
            SHIFT:   if (last_bit)               next_state = HOLD;
            HOLD:    if (frame_end)              next_state = IDLE;
            default:                             next_state = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_busy  = ~o_ready;
        o_state = state;
    end

    // Setup/hold counter only runs inside SETUP or HOLD and clears on every state change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_cnt <= '0;
        end else if ((next_state != state) || !((state == SETUP) || (state == HOLD))) begin
            cs_cnt <= '0;
        end else begin
            cs_cnt <= cs_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt <= '0;
        end else if (state != SHIFT) begin
            bit_cnt <= '0;
        end else if (fall_stb) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    // MOSI is the top bit of tx_shift; it is left on the LSB after the last fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            o_rx_data <= '0;
            spi_cs_n  <= 1'b1;
            o_done    <= 1'b0;
        end else begin
            o_done   <= frame_end;
            spi_cs_n <= (next_state == IDLE);
            if (accept) begin
                tx_shift <= i_data;
                rx_shift <= '0;
            end else if (frame_end) begin
                o_rx_data <= rx_shift;
                tx_shift  <= '0;
            end else if (state == SHIFT) begin
                if (rise_stb) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], spi_miso};
                end
                if (fall_stb && !last_bit) begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: default instance plus a 16-bit CLK_DIV=2 instance,
// with a synchroniser/debouncer model of the receiving slave on the default outputs.
module tb_spi_master_tx;
    import spi_pkg::*;

    logic clk;
    logic rst;

    logic       valid;
    logic [7:0] data_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    spi_state_e st;

    logic        valid16;
    logic [15:0] data16;
    logic        ready16;
    logic        busy16;
    logic        done16;
    logic [15:0] rx16;
    logic        sclk16;
    logic        mosi16;
    logic        cs16;
    logic        miso16;
    spi_state_e  st16;

    int checks = 0;
    int errors = 0;
    int miso_mode = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[6];

    spi_master_tx dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_data    (data_in),
        .o_ready   (ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_rx_data (rx_data),
        .spi_clk   (sclk),
        .spi_mosi  (mosi),
        .spi_cs_n  (cs_n),
        .spi_miso  (miso),
        .o_state   (st)
    );

    spi_master_tx #(
        .DATA_WIDTH (16),
        .CLK_DIV    (2),
        .CS_SETUP   (1),
        .CS_HOLD    (1)
    ) dut16 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid16),
        .i_data    (data16),
        .o_ready   (ready16),
        .o_busy    (busy16),
        .o_done    (done16),
        .o_rx_data (rx16),
        .spi_clk   (sclk16),
        .spi_mosi  (mosi16),
        .spi_cs_n  (cs16),
        .spi_miso  (miso16),
        .o_state   (st16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiving-side model: 2-flop synchroniser, then follow only after 2 equal samples.
    logic [1:0]  sync_clk;
    logic [1:0]  sync_mosi;
    logic        last_clk_s;
    logic        last_mosi_s;
    logic        deb_clk;
    logic        deb_mosi;
    logic        deb_clk_seen = 1'b0;
    int          deb_rises = 0;
    logic [31:0] deb_bits = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_clk    <= '0;
            sync_mosi   <= '0;
            last_clk_s  <= 1'b0;
            last_mosi_s <= 1'b0;
            deb_clk     <= 1'b0;
            deb_mosi    <= 1'b0;
        end else begin
            sync_clk    <= {sync_clk[0], sclk};
            sync_mosi   <= {sync_mosi[0], mosi};
            last_clk_s  <= sync_clk[1];
            last_mosi_s <= sync_mosi[1];
            if (sync_clk[1] == last_clk_s) deb_clk <= sync_clk[1];
            if (sync_mosi[1] == last_mosi_s) deb_mosi <= sync_mosi[1];
        end
    end

    always @(negedge clk) begin
        if (deb_clk && !deb_clk_seen) begin
            deb_rises <= deb_rises + 1;
            deb_bits  <= {deb_bits[30:0], deb_mosi};
        end
        deb_clk_seen <= deb_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (first cycle after the accept edge).
    task automatic start_frame(input logic [7:0] d, input logic [7:0] exp_rx, input int mode, input logic hold);
        check("ready_before", ready, 1'b1);
        valid     = 1'b1;
        data_in   = d;
        miso_mode = mode;
        exp_q.push_back(exp_rx);
        @(negedge clk);
        if (!hold) valid = 1'b0;
    endtask

    // Watches one default-instance frame from cycle 1 up to the o_done cycle.
    task automatic monitor_frame(input logic [7:0] d, input int poke_cyc, input logic chain,
                                 input logic [7:0] next_d);
        int         cs_low;
        int         rises;
        int         run;
        int         bad_runs;
        int         done_cyc;
        logic       prev_clk;
        logic       after_fall;
        logic [7:0] bits;
        logic [7:0] exp_rx;
        cs_low = 0; rises = 0; run = 0; bad_runs = 0; done_cyc = 0;
        prev_clk = 1'b0; after_fall = 1'b0; bits = '0;
        for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
            if (cyc == 1) begin
                check("cs_n_latency", cs_n, 1'b0);
                check("busy_c1", {busy, ready}, 2'b10);
            end
            if (!cs_n) cs_low++;
            if (sclk && !prev_clk) begin
                rises++;
                bits = {bits[6:0], mosi};
                if (after_fall && run != 4) bad_runs++;
                run = 0;
            end else if (!sclk && prev_clk) begin
                if (run != 4) bad_runs++;
                run = 0;
                after_fall = 1'b1;
            end
            run++;
            prev_clk = sclk;
            if (poke_cyc > 0 && cyc == poke_cyc) begin
                valid   = 1'b1;
                data_in = 8'hFF;
            end else if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
                valid = 1'b0;
            end
            miso = (miso_mode == 0) ? mosi : (miso_mode == 2);
            if (done) begin
                done_cyc = cyc;
                if (chain) data_in = next_d;
            end else begin
                @(negedge clk);
            end
        end
        exp_rx = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("done_cycle", done_cyc, 69);
        check("cs_low_len", cs_low, 68);
        check("sclk_pulses", rises, 8);
        check("sclk_phase_len", bad_runs, 0);
        check("mosi_bits", bits, d);
        check("done_cs_mosi", {cs_n, mosi}, 2'b10);
        check("rx_data", rx_data, exp_rx);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, mode: 0, exp_rx: 8'hA5};
        vecs[1] = '{data: 8'h5A, mode: 1, exp_rx: 8'h00};
        vecs[2] = '{data: 8'h5A, mode: 2, exp_rx: 8'hFF};
        vecs[3] = '{data: 8'h80, mode: 0, exp_rx: 8'h80};
        vecs[4] = '{data: 8'h01, mode: 0, exp_rx: 8'h01};
        vecs[5] = '{data: 8'hC6, mode: 2, exp_rx: 8'hFF};

        rst = 1'b1; valid = 1'b0; data_in = '0; miso = 1'b0;
        valid16 = 1'b0; data16 = '0; miso16 = 1'b0;
        idle(3);
        check("rst_spi", {cs_n, sclk, mosi}, 3'b100);
        check("rst_hs", {ready, busy, done}, 3'b100);
        check("rst_rx", rx_data, 8'h00);
        check("rst_state", st, IDLE);
        check("rst_state16", {st16, cs16, ready16}, {IDLE, 2'b11});
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            int base;
            base = deb_rises;
            start_frame(vecs[i].data, vecs[i].exp_rx, vecs[i].mode, 1'b0);
            monitor_frame(vecs[i].data, 0, 1'b0, 8'h00);
            @(negedge clk);
            check("done_pulse", done, 1'b0);
            idle(3);
            check("rx_hold", rx_data, vecs[i].exp_rx);
            check("deb_rises", deb_rises - base, 8);
            check("deb_bits", deb_bits[7:0], vecs[i].data);
        end

        // Back-to-back with valid held: second accept lands on the o_done cycle.
        start_frame(8'h3C, 8'h3C, 0, 1'b1);
        exp_q.push_back(8'hC3);
        monitor_frame(8'h3C, 0, 1'b1, 8'hC3);
        @(negedge clk);
        valid = 1'b0;
        monitor_frame(8'hC3, 0, 1'b0, 8'h00);
        idle(2);

        // A word offered mid-frame is ignored and produces no extra frame.
        begin
            int extra;
            start_frame(8'h12, 8'h12, 0, 1'b0);
            monitor_frame(8'h12, 20, 1'b0, 8'h00);
            extra = 0;
            repeat (80) begin
                @(negedge clk);
                if (done || !cs_n) extra++;
            end
            check("busy_ignore", extra, 0);
            check("busy_ignore_rx", rx_data, 8'h12);
        end

        // Asynchronous reset during the fourth high phase aborts the frame.
        begin
            int nd;
            valid = 1'b1; data_in = 8'h77; miso_mode = 0;
            @(negedge clk);
            valid = 1'b0;
            repeat (31) @(negedge clk);
            check("pre_rst", {cs_n, sclk, mosi}, 3'b011);
            rst = 1'b1;
            #1;
            check("async_rst_spi", {cs_n, sclk, mosi}, 3'b100);
            check("async_rst_hs", {ready, busy}, 2'b10);
            check("async_rst_rx", rx_data, 8'h00);
            nd = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) nd++;
            end
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("abort_no_done", nd, 0);
            start_frame(8'h81, 8'h81, 0, 1'b0);
            monitor_frame(8'h81, 0, 1'b0, 8'h00);
            idle(2);
        end

        // 16-bit, CLK_DIV=2, one-cycle setup/hold instance with MISO tied low.
        begin
            int          cs_low;
            int          rises;
            int          done_cyc;
            logic        prev;
            logic [15:0] bits16;
            check("ready16", ready16, 1'b1);
            valid16 = 1'b1; data16 = 16'h8001; miso16 = 1'b0;
            @(negedge clk);
            valid16 = 1'b0;
            cs_low = 0; rises = 0; done_cyc = 0; prev = 1'b0; bits16 = '0;
            for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
                if (!cs16) cs_low++;
                if (sclk16 && !prev) begin
                    rises++;
                    bits16 = {bits16[14:0], mosi16};
                end
                prev = sclk16;
                if (done16) done_cyc = cyc;
                else @(negedge clk);
            end
            check("w16_cs_low", cs_low, 66);
            check("w16_pulses", rises, 16);
            check("w16_first_last", {bits16[15], bits16[0]}, 2'b11);
            check("w16_bits", bits16, 16'h8001);
            check("w16_done_cycle", done_cyc, 67);
            check("w16_rx", rx16, 16'h0000);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
